// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access sequencer and its lane aligner.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        FAULT = 3'd5
    } state_t;

    // The reserved encoding 2'b11 behaves exactly like a word access.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/halfword lane extraction with sign/zero extension, and lane merge for
// read-modify-write stores. Purely combinational.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [WORD_W-1:0] rd_word,
    input  logic [WORD_W-1:0] base_word,
    input  logic [1:0]        offset,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] ext_data,
    output logic [WORD_W-1:0] merged_word
);
    logic [4:0]        byte_lsb;
    logic [BYTE_W-1:0] rd_byte;
    logic [HALF_W-1:0] rd_half;

    assign byte_lsb = {offset, 3'b000};
    assign rd_byte  = rd_word[byte_lsb +: BYTE_W];
    // Halfword lane follows offset[1] alone; offset[0] never shifts a half.
    assign rd_half  = offset[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ext_data = rd_word;
        if (size == SZ_BYTE)
            ext_data = {{(WORD_W-BYTE_W){rd_byte[BYTE_W-1] & ~unsigned_ld}}, rd_byte};
        else if (size == SZ_HALF)
            ext_data = {{(WORD_W-HALF_W){rd_half[HALF_W-1] & ~unsigned_ld}}, rd_half};
    end

    always_comb begin
        merged_word = wdata;
        if (size == SZ_BYTE) begin
            merged_word = base_word;
            merged_word[byte_lsb +: BYTE_W] = wdata[BYTE_W-1:0];
        end else if (size == SZ_HALF) begin
            merged_word = base_word;
            if (offset[1])
                merged_word[31:16] = wdata[HALF_W-1:0];
            else
                merged_word[15:0] = wdata[HALF_W-1:0];
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the word-wide Memoria block; sub-word stores
// are read-modify-write. Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 32
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [31:0]       mem_datain,
    input  logic [31:0]       mem_dataout,
    output state_t            state_dbg
);
    localparam logic [1:0] LAST_CNT = 2'(READ_LATENCY - 1);
`ifdef MEM_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    state_t      state, next_state;
    logic        is_store_q, unsigned_q, trap, read_last;
    logic [1:0]  size_q, offset_q, cnt;
    logic [31:0] wdata_q, word_q, ext_data, merged_word;

    assign trap      = TRAP_EN && ((size == SZ_HALF && addr[0]) ||
                                   (is_word(size) && addr[1:0] != 2'b00));
    assign read_last = (cnt == LAST_CNT);
    assign state_dbg = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Handshake: start is sampled only in IDLE; busy covers every non-IDLE
    // state, and done pulses for the single DONE cycle. All Moore outputs.
    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        mem_wr     = 1'b0;
        misalign   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (trap)
                        next_state = FAULT;
                    else if (is_store && is_word(size))
                        next_state = WRITE;
                    else
                        next_state = READ;
                end
            end
            READ:  if (read_last) next_state = is_store_q ? MERGE : DONE;
            MERGE: next_state = WRITE;
            WRITE: begin
                mem_wr     = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            FAULT: begin
                misalign   = TRAP_EN;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            is_store_q <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= 2'b00;
            offset_q   <= 2'b00;
            cnt        <= 2'b00;
            wdata_q    <= '0;
            word_q     <= '0;
            load_data  <= '0;
            mem_addr   <= '0;
            mem_datain <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        is_store_q <= is_store;
                        unsigned_q <= unsigned_ld;
                        size_q     <= size;
                        offset_q   <= addr[1:0];
                        wdata_q    <= wdata;
                        mem_addr   <= {addr[ADDR_W-1:2], 2'b00};
                        mem_datain <= wdata;
                        cnt        <= 2'b00;
                    end
                end
                READ: begin
                    cnt <= cnt + 2'd1;
                    // Extension happens here so load_data is already final in DONE.
                    if (read_last) begin
                        word_q <= mem_dataout;
                        if (!is_store_q)
                            load_data <= ext_data;
                    end
                end
                MERGE:   mem_datain <= merged_word;
                default: ;
            endcase
        end
    end

    mem_lane_align u_align (
        .rd_word     (mem_dataout),
        .base_word   (word_q),
        .offset      (offset_q),
        .size        (size_q),
        .unsigned_ld (unsigned_q),
        .wdata       (wdata_q),
        .ext_data    (ext_data),
        .merged_word (merged_word)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (READ_LATENCY 1 and 3), each with a
// word memory model whose read data is only valid READ_LATENCY cycles after the address.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam int N = 2;

    logic clock = 1'b0;
    logic reset;
    logic mem_init;

    logic        start       [N];
    logic        is_store    [N];
    logic [1:0]  size        [N];
    logic        unsigned_ld [N];
    logic [31:0] addr        [N];
    logic [31:0] wdata       [N];
    logic        busy        [N];
    logic        done        [N];
    logic [31:0] load_data   [N];
    logic        misalign    [N];
    logic [31:0] mem_addr    [N];
    logic        mem_wr      [N];
    logic [31:0] mem_datain  [N];
    logic [31:0] mem_dataout [N];
    state_t      state_dbg   [N];

    logic [31:0] mem [N][256];
    int          wr_cnt       [N];
    int          mis_cnt      [N];
    logic [31:0] last_wr_addr [N];
    logic [31:0] prev_addr    [N];
    int          age          [N];

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q [$];
    int          lat_q [$];

    always #5 clock = ~clock;

    function automatic int rl_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_access_unit #(.READ_LATENCY(g == 0 ? 1 : 3), .ADDR_W(32)) dut (
            .clock       (clock),
            .reset       (reset),
            .start       (start[g]),
            .is_store    (is_store[g]),
            .size        (size[g]),
            .unsigned_ld (unsigned_ld[g]),
            .addr        (addr[g]),
            .wdata       (wdata[g]),
            .busy        (busy[g]),
            .done        (done[g]),
            .load_data   (load_data[g]),
            .misalign    (misalign[g]),
            .mem_addr    (mem_addr[g]),
            .mem_wr      (mem_wr[g]),
            .mem_datain  (mem_datain[g]),
            .mem_dataout (mem_dataout[g]),
            .state_dbg   (state_dbg[g])
        );
    end

    // Read data is garbage until the address has been held for READ_LATENCY cycles.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            int held;
            held = (mem_addr[i] === prev_addr[i]) ? age[i] + 1 : 1;
            mem_dataout[i] = (held >= rl_of(i)) ? mem[i][mem_addr[i][9:2]] : 32'hBAD0_0BAD;
        end
    end

    always @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (mem_init) begin
                for (int k = 0; k < 256; k++) mem[i][k] <= 32'h0;
                mem[i][64]      <= 32'h8899_AABB;
                mem[i][65]      <= 32'h0102_0304;
                wr_cnt[i]       <= 0;
                mis_cnt[i]      <= 0;
                last_wr_addr[i] <= 32'h0;
            end else begin
                if (mem_wr[i]) begin
                    mem[i][mem_addr[i][9:2]] <= mem_datain[i];
                    wr_cnt[i]       <= wr_cnt[i] + 1;
                    last_wr_addr[i] <= mem_addr[i];
                end
                if (misalign[i]) mis_cnt[i] <= mis_cnt[i] + 1;
            end
            age[i]       <= (mem_addr[i] === prev_addr[i]) ? age[i] + 1 : 1;
            prev_addr[i] <= mem_addr[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One operation: expectations queued at start, popped when done appears.
    task automatic run_op(input int i, input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_ld, input int exp_lat, input int exp_wr,
                          input bit poke);
        int n;
        int w0;
        @(negedge clock);
        is_store[i] = st; size[i] = sz; unsigned_ld[i] = uns; addr[i] = a; wdata[i] = wd;
        start[i] = 1'b1;
        exp_q.push_back(exp_ld);
        lat_q.push_back(exp_lat);
        w0 = wr_cnt[i];
        @(negedge clock);
        start[i]       = 1'b0;
        is_store[i]    = 1'($urandom_range(0, 1));
        size[i]        = 2'($urandom_range(0, 3));
        unsigned_ld[i] = 1'($urandom_range(0, 1));
        addr[i]        = $urandom;
        wdata[i]       = $urandom;
        n = 1;
        while (!done[i] && n < 20) begin
            if (poke) start[i] = 1'($urandom_range(0, 1));
            @(negedge clock);
            n++;
        end
        start[i] = 1'b0;
        check("done_seen", 32'(done[i]), 32'd1);
        check("busy_in_done", 32'(busy[i]), 32'd1);
        check("latency", n, lat_q.pop_front());
        check("load_data", load_data[i], exp_q.pop_front());
        check("write_cycles", wr_cnt[i] - w0, exp_wr);
        @(negedge clock);
        check("done_pulse", 32'(done[i]), 32'd0);
        check("busy_after", 32'(busy[i]), 32'd0);
    endtask

`ifdef MEM_MISALIGN_TRAP_EN
    task automatic run_trap(input int i, input logic st, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd);
        int w0;
        int m0;
        int seen_done;
        @(negedge clock);
        is_store[i] = st; size[i] = sz; unsigned_ld[i] = 1'b0; addr[i] = a; wdata[i] = wd;
        start[i] = 1'b1;
        w0 = wr_cnt[i];
        m0 = mis_cnt[i];
        @(negedge clock);
        start[i] = 1'b0;
        check("trap_busy", 32'(busy[i]), 32'd1);
        check("trap_misalign", 32'(misalign[i]), 32'd1);
        seen_done = 0;
        repeat (6) begin
            @(negedge clock);
            if (done[i]) seen_done++;
        end
        check("trap_pulses", mis_cnt[i] - m0, 32'd1);
        check("trap_no_done", seen_done, 32'd0);
        check("trap_no_write", wr_cnt[i] - w0, 32'd0);
        check("trap_idle", 32'(busy[i]), 32'd0);
    endtask
`endif

    initial begin
        logic [31:0] w64;
        logic [31:0] ld0;
        int          w0;

        reset = 1'b1;
        mem_init = 1'b1;
        for (int i = 0; i < N; i++) begin
            start[i] = 1'b0; is_store[i] = 1'b0; size[i] = 2'b00; unsigned_ld[i] = 1'b0;
            addr[i] = 32'h0; wdata[i] = 32'h0;
        end
        repeat (3) @(negedge clock);
        for (int i = 0; i < N; i++) begin
            check("rst_busy", 32'(busy[i]), 32'd0);
            check("rst_done", 32'(done[i]), 32'd0);
            check("rst_mem_wr", 32'(mem_wr[i]), 32'd0);
            check("rst_load_data", load_data[i], 32'h0);
            check("rst_mem_addr", mem_addr[i], 32'h0);
            check("rst_state", state_dbg[i], IDLE);
        end
        mem_init = 1'b0;
        reset = 1'b0;

        // Instance 0, READ_LATENCY = 1: load matrix, sub-word and word stores.
        run_op(0, 1'b0, SZ_BYTE, 1'b0, 32'h100, 32'h0, 32'hFFFF_FFBB, 2, 0, 1'b0);
        run_op(0, 1'b0, SZ_BYTE, 1'b1, 32'h101, 32'h0, 32'h0000_00AA, 2, 0, 1'b0);
        run_op(0, 1'b0, SZ_HALF, 1'b0, 32'h102, 32'h0, 32'hFFFF_8899, 2, 0, 1'b0);
        run_op(0, 1'b0, SZ_HALF, 1'b1, 32'h100, 32'h0, 32'h0000_AABB, 2, 0, 1'b0);
        run_op(0, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'h8899_AABB, 2, 0, 1'b0);
        run_op(0, 1'b1, SZ_BYTE, 1'b0, 32'h102, 32'h1234_5611, 32'h8899_AABB, 4, 1, 1'b0);
        check("sb_word", mem[0][64], 32'h8811_AABB);
        run_op(0, 1'b1, SZ_WORD, 1'b0, 32'h104, 32'hDEAD_BEEF, 32'h8899_AABB, 2, 1, 1'b0);
        check("sw_word", mem[0][65], 32'hDEAD_BEEF);
        check("sw_addr", last_wr_addr[0], 32'h104);
        run_op(0, 1'b0, SZ_WORD, 1'b0, 32'h104, 32'h0, 32'hDEAD_BEEF, 2, 0, 1'b0);
        ld0 = 32'hDEAD_BEEF;
        w64 = 32'h8811_AABB;

`ifdef MEM_MISALIGN_TRAP_EN
        run_trap(0, 1'b0, SZ_WORD, 32'h102, 32'h0);
        run_trap(0, 1'b1, SZ_HALF, 32'h103, 32'h0000_BEEF);
        check("trap_mem", mem[0][64], w64);
        check("trap_load_data", load_data[0], ld0);
`else
        run_op(0, 1'b0, SZ_WORD, 1'b0, 32'h102, 32'h0, w64, 2, 0, 1'b0);
        ld0 = w64;
        run_op(0, 1'b1, SZ_HALF, 1'b0, 32'h103, 32'h0000_BEEF, ld0, 4, 1, 1'b0);
        w64 = {16'hBEEF, w64[15:0]};
        check("sh_hi_word", mem[0][64], w64);
        check("misalign_tied", mis_cnt[0], 32'd0);
`endif

        // Reset while an sb sits in WRITE: the write must never land.
        @(negedge clock);
        is_store[0] = 1'b1; size[0] = SZ_BYTE; unsigned_ld[0] = 1'b0;
        addr[0] = 32'h100; wdata[0] = 32'h0000_00FF; start[0] = 1'b1;
        w0 = wr_cnt[0];
        @(negedge clock);
        start[0] = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rst_mid_wr_high", 32'(mem_wr[0]), 32'd1);
        #1 reset = 1'b1;
        #1 check("rst_mid_wr_async", 32'(mem_wr[0]), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst_mid_busy", 32'(busy[0]), 32'd0);
        check("rst_mid_done", 32'(done[0]), 32'd0);
        check("rst_mid_load_data", load_data[0], 32'h0);
        check("rst_mid_mem_addr", mem_addr[0], 32'h0);
        check("rst_mid_datain", mem_datain[0], 32'h0);
        check("rst_mid_state", state_dbg[0], IDLE);
        repeat (3) @(negedge clock);
        check("rst_mid_mem", mem[0][64], w64);
        check("rst_mid_writes", wr_cnt[0] - w0, 32'd0);
        run_op(0, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, w64, 2, 0, 1'b0);

        // Instance 1, READ_LATENCY = 3, with start pokes during busy on the store.
        run_op(1, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'h8899_AABB, 4, 0, 1'b0);
        run_op(1, 1'b0, SZ_WORD, 1'b0, 32'h104, 32'h0, 32'h0102_0304, 4, 0, 1'b0);
        run_op(1, 1'b1, SZ_HALF, 1'b0, 32'h100, 32'h0000_CAFE, 32'h0102_0304, 6, 1, 1'b1);
        check("sh_word", mem[1][64], 32'h8899_CAFE);
        run_op(1, 1'b0, SZ_BYTE, 1'b0, 32'h103, 32'h0, 32'hFFFF_FF88, 4, 0, 1'b1);
        run_op(1, 1'b0, SZ_HALF, 1'b1, 32'h100, 32'h0, 32'h0000_CAFE, 4, 0, 1'b0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sequencer between the multicycle datapath and the byte-addressed Memoria block; executes lw/lh/lhu/lb/lbu/sw/sh/sb.
- Sub-word stores are done as read-modify-write: read the word, merge the lane, write the word back.
- Loads return extracted, sign- or zero-extended data, which the datapath writes into the load-size register.
- Replaces direct Wr/Datain driving by the control unit with a start/busy/done handshake.

Parameters:
- READ_LATENCY, 1, cycles from driving mem_addr to valid mem_dataout (legal range 1..4).
- ADDR_W, 32, byte-address width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- unsigned_ld  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data; low 8/16/32 bits used.
- busy  out  1  high from the accepting edge until DONE exits.
- done  out  1  one-cycle pulse in DONE.
- load_data  out  32  registered extended load result.
- misalign  out  1  one-cycle pulse; present only with the optional feature.
- mem_addr  out  ADDR_W  to Memoria Address, word-aligned (addr & ~3).
- mem_wr  out  1  to Memoria Wr.
- mem_datain  out  32  to Memoria Datain.
- mem_dataout  in  32  from Memoria Dataout.

Behaviour:
- Byte lanes are little-endian: offset 0 = bits 7:0, offset 3 = bits 31:24. Halfword lane is addr[1]: 0 = bits 15:0, 1 = bits 31:16.
- Reset (async) sets state = IDLE and clears busy, done, load_data, misalign, mem_wr, mem_datain, mem_addr and the read counter.
- Reset mid-operation aborts immediately. mem_wr drops asynchronously; no partial write is committed after reset deasserts.
- States and transitions:
  - IDLE: on start, latch is_store/size/unsigned_ld/addr/wdata, then:
    - sw → WRITE.
    - any load, sb or sh → READ.
  - READ: mem_addr is the aligned address, mem_wr = 0. The counter increments each edge. On the edge where counter = READ_LATENCY-1, capture mem_dataout into the word register, then go to DONE (load) or MERGE (sb/sh).
  - MERGE: replace the addressed lane of the word register with wdata[7:0] or wdata[15:0] → WRITE.
  - WRITE: mem_wr = 1, mem_datain = merged word (or latched wdata for sw). Memoria commits on the exit edge → DONE.
  - DONE: done = 1 and load_data is valid (extension is applied at the READ capture) → IDLE.
- Latency in edges, from the accepting edge to done rising: load = READ_LATENCY+1; sw = 2; sb/sh = READ_LATENCY+3.
- Signal rules:
  - mem_wr, busy and done are decoded from the state register only (Moore, glitch-free).
  - start while busy is ignored, not queued.
  - Input changes after acceptance have no effect.
  - load_data holds its value until the next load completes; stores leave it unchanged.
- No back-to-back bypass: IDLE always lasts at least one cycle between operations.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - A halfword with addr[0] = 1, or a word with addr[1:0] ≠ 0, goes IDLE → FAULT → IDLE.
  - FAULT asserts misalign for one cycle, with no memory access, no done and busy high.
  - The control unit uses misalign to enter exception handling.
- Undefined:
  - The misalign port is tied 0.
  - Low address bits are ignored for lane selection: half uses addr[1] only, word uses offset 0.
  - The access proceeds normally.

Decomposition:
- Package mem_access_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - state encoding (IDLE, READ, MERGE, WRITE, DONE, FAULT);
  - the lane-width constants.
- One combinational sub-module, mem_lane_align, provides:
  - extract: word, offset, size, unsigned → 32-bit extended value;
  - merge: word, offset, size, wdata → 32-bit word.
- The FSM, counter and latches stay in mem_access_unit.

Test Plan:
- Load matrix, memory word 0x8899AABB at 0x100, READ_LATENCY = 1:
  - lb 0x100 → load_data 0xFFFFFFBB, done 2 edges after accept;
  - lbu 0x101 → 0x000000AA;
  - lh 0x102 → 0xFFFF8899;
  - lw 0x100 → 0x8899AABB.
- sb 0x102 with wdata 0x12345611 → word 0x8811AABB. mem_wr is high exactly one cycle; done 4 edges after accept.
- sh 0x100 with wdata 0x0000CAFE, READ_LATENCY = 3 → word 0x8899CAFE; done 6 edges after accept; start pulses during busy are ignored.
- sw 0x104 with 0xDEADBEEF → mem_wr high one cycle with mem_addr 0x104; done 2 edges after accept; load_data unchanged.
- With MEM_MISALIGN_TRAP_EN, lw 0x102 and sh 0x103 → misalign pulse, mem_wr never high, done stays 0, memory unchanged.
- Reset asserted during WRITE of sb 0x100 → mem_wr falls before the next edge. After release: word unchanged, busy 0, outputs 0; the next lw succeeds.
